// File: rtl/exe_stage_if.sv
// ID/EX operand/control bundle into exe_stage and its EXE/MEM results back out.
// FORWARDING_EN adds the forwarding select and value lines.
interface exe_stage_if;
`ifdef FORWARDING_EN
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] fwd_mem_val;
  logic [31:0] fwd_wb_val;
`endif
  logic        wb_en_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        B_in;
  logic        S_in;
  logic        imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] PC_in;
  logic [31:0] val_Rn_in;
  logic [31:0] val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;

  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  SR;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [3:0]  dest;

  modport master (
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
`endif
    output wb_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in, exe_cmd_in,
    output PC_in, val_Rn_in, val_Rm_in, shift_operand_in, signed_imm_24_in, dest_in,
    input  branch_taken, branch_addr, SR, wb_en, mem_read, mem_write, alu_res, st_val, dest
  );

  modport slave (
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
`endif
    input  wb_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in, exe_cmd_in,
    input  PC_in, val_Rn_in, val_Rm_in, shift_operand_in, signed_imm_24_in, dest_in,
    output branch_taken, branch_addr, SR, wb_en, mem_read, mem_write, alu_res, st_val, dest
  );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: barrel-shifted operand 2, ALU, NZCV register, branch target; 1-cycle EXE/MEM latency.
// Optional operand forwarding muxes are enabled with `define FORWARDING_EN.
module exe_stage #(
  parameter int DW = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      stall,
  exe_stage_if.slave bus
);

  function automatic logic [DW-1:0] f_ror(input logic [DW-1:0] x, input logic [4:0] a);
    f_ror = (x >> a) | (x << (6'd32 - {1'b0, a}));
  endfunction

  logic [DW-1:0] w_rn;
  logic [DW-1:0] w_rm;
  logic [DW-1:0] w_val2;
  logic [DW-1:0] w_res;
  logic [DW:0]   w_sum;
  logic [4:0]    w_shamt;
  logic          w_n, w_z, w_c, w_v;
  logic          w_cin;
  logic          w_known;

  logic          r_wb_en;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [DW-1:0] r_alu_res;
  logic [DW-1:0] r_st_val;
  logic [3:0]    r_dest;
  logic [3:0]    r_sr;

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      2'b01:   w_rn = bus.fwd_mem_val;
      2'b10:   w_rn = bus.fwd_wb_val;
      default: w_rn = bus.val_Rn_in;
    endcase
    case (bus.sel_src2)
      2'b01:   w_rm = bus.fwd_mem_val;
      2'b10:   w_rm = bus.fwd_wb_val;
      default: w_rm = bus.val_Rm_in;
    endcase
  end
`else
  assign w_rn = bus.val_Rn_in;
  assign w_rm = bus.val_Rm_in;
`endif

  assign w_shamt = bus.shift_operand_in[11:7];

  // Immediate takes priority over the load/store offset form.
  always_comb begin
    w_val2 = '0;
    if (bus.imm_in) begin
      w_val2 = f_ror({24'b0, bus.shift_operand_in[7:0]}, {bus.shift_operand_in[11:8], 1'b0});
    end else if (bus.mem_read_in || bus.mem_write_in) begin
      w_val2 = {20'b0, bus.shift_operand_in};
    end else begin
      case (bus.shift_operand_in[6:5])
        2'b00:   w_val2 = w_rm << w_shamt;
        2'b01:   w_val2 = w_rm >> w_shamt;
        2'b10:   w_val2 = $unsigned($signed(w_rm) >>> w_shamt);
        default: w_val2 = f_ror(w_rm, w_shamt);
      endcase
    end
  end

  assign w_cin = r_sr[1];

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_known = 1'b1;
    {w_n, w_z, w_c, w_v} = r_sr;
    case (bus.exe_cmd_in)
      4'b0001: w_res = w_val2;
      4'b1001: w_res = ~w_val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, w_rn} + {1'b0, w_val2}
              + {{DW{1'b0}}, (bus.exe_cmd_in[0] & w_cin)};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (w_rn[DW-1] == w_val2[DW-1]) && (w_sum[DW-1] != w_rn[DW-1]);
      end
      4'b0100, 4'b0101: begin
        // C is the inverted borrow out of the 33-bit subtraction.
        w_sum = {1'b0, w_rn} - {1'b0, w_val2}
              - {{DW{1'b0}}, (bus.exe_cmd_in[0] & ~w_cin)};
        w_res = w_sum[DW-1:0];
        w_c   = ~w_sum[DW];
        w_v   = (w_rn[DW-1] != w_val2[DW-1]) && (w_sum[DW-1] != w_rn[DW-1]);
      end
      4'b0110: w_res = w_rn & w_val2;
      4'b0111: w_res = w_rn | w_val2;
      4'b1000: w_res = w_rn ^ w_val2;
      default: w_known = 1'b0;
    endcase
    if (w_known) begin
      w_n = w_res[DW-1];
      w_z = (w_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_res   <= '0;
      r_st_val    <= '0;
      r_dest      <= '0;
      r_sr        <= '0;
    end else if (!stall) begin
      r_wb_en     <= bus.wb_en_in;
      r_mem_read  <= bus.mem_read_in;
      r_mem_write <= bus.mem_write_in;
      r_alu_res   <= w_res;
      r_st_val    <= w_rm;
      r_dest      <= bus.dest_in;
      if (bus.S_in) r_sr <= {w_n, w_z, w_c, w_v};
    end
  end

  assign bus.branch_taken = bus.B_in;
  assign bus.branch_addr  = bus.PC_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};
  assign bus.SR           = r_sr;
  assign bus.wb_en        = r_wb_en;
  assign bus.mem_read     = r_mem_read;
  assign bus.mem_write    = r_mem_write;
  assign bus.alu_res      = r_alu_res;
  assign bus.st_val       = r_st_val;
  assign bus.dest         = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus random operations checked against an arithmetic reference model.
module tb_exe_stage;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk;
  logic rst;
  logic stall;
  int   n_checks;
  int   n_err;

  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest, m_sr;

  exe_stage_if bus ();

  exe_stage dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_ror(input logic [31:0] x, input int r);
    logic [63:0] t;
    t = {32'b0, x} * (64'd1 << (32 - r));
    return t[31:0] | t[63:32];
  endfunction

  function automatic logic [31:0] mdl_val2(input logic imm, input logic memop,
                                           input logic [11:0] so, input logic [31:0] rm);
    int s;
    logic [63:0] t;
    s = int'(so[11:7]);
    if (imm) return mdl_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
    if (memop) return {20'b0, so};
    case (so[6:5])
      2'b00: begin
        t = {32'b0, rm} * (64'd1 << s);
        return t[31:0];
      end
      2'b01:   return rm / (32'd1 << s);
      2'b10:   return (rm / (32'd1 << s)) | (rm[31] ? ~(32'hFFFFFFFF >> s) : 32'd0);
      default: return mdl_ror(rm, s);
    endcase
  endfunction

  function automatic void mdl_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                  input logic [3:0] sr, output logic [31:0] res, output logic [3:0] nsr);
    longint ua, ub, u, sa, sb, sv, extra;
    logic n, z, c, v, known;
    ua = longint'(rn);
    ub = longint'(v2);
    sa = longint'($signed(rn));
    sb = longint'($signed(v2));
    {n, z, c, v} = sr;
    known = 1'b1;
    res = 32'd0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2, 4'd3: begin
        extra = (cmd == 4'd3 && sr[1]) ? 64'sd1 : 64'sd0;
        u  = ua + ub + extra;
        sv = sa + sb + extra;
        res = 32'(u);
        c = (u > 64'sd4294967295);
        v = (sv > MAXS) || (sv < MINS);
      end
      4'd4, 4'd5: begin
        extra = (cmd == 4'd5 && !sr[1]) ? 64'sd1 : 64'sd0;
        u  = ua - ub - extra;
        sv = sa - sb - extra;
        res = 32'(u);
        c = (ua >= ub + extra);
        v = (sv > MAXS) || (sv < MINS);
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      n = res[31];
      z = (res == 32'd0);
    end
    nsr = {n, z, c, v};
  endfunction

  task automatic check_regs(input string pfx);
    chk({pfx, ".wb_en"},     32'(bus.wb_en),     32'(m_wb));
    chk({pfx, ".mem_read"},  32'(bus.mem_read),  32'(m_mr));
    chk({pfx, ".mem_write"}, 32'(bus.mem_write), 32'(m_mw));
    chk({pfx, ".alu_res"},   bus.alu_res,        m_alu);
    chk({pfx, ".st_val"},    bus.st_val,         m_st);
    chk({pfx, ".dest"},      32'(bus.dest),      32'(m_dest));
    chk({pfx, ".SR"},        32'(bus.SR),        32'(m_sr));
  endtask

  task automatic model_reset();
    m_wb = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_st = 0; m_dest = 0; m_sr = 0;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] dflt,
                                       input logic [31:0] fm, input logic [31:0] fw);
    return (sel == 2'b01) ? fm : (sel == 2'b10) ? fw : dflt;
  endfunction

  // Called just after a negedge with inputs driven; returns at the following negedge.
  task automatic cycle(input string pfx);
    logic [31:0] rn, rm, v2, res, exp_ba;
    logic [3:0]  nsr;
    int off;
    rn = bus.val_Rn_in;
    rm = bus.val_Rm_in;
`ifdef FORWARDING_EN
    rn = pick(bus.sel_src1, rn, bus.fwd_mem_val, bus.fwd_wb_val);
    rm = pick(bus.sel_src2, rm, bus.fwd_mem_val, bus.fwd_wb_val);
`endif
    v2 = mdl_val2(bus.imm_in, bus.mem_read_in | bus.mem_write_in, bus.shift_operand_in, rm);
    mdl_alu(bus.exe_cmd_in, rn, v2, m_sr, res, nsr);
    off = int'(bus.signed_imm_24_in);
    if (off >= 8388608) off = off - 16777216;
    exp_ba = bus.PC_in + 32'(off * 4);
    #1;
    chk({pfx, ".branch_taken"}, 32'(bus.branch_taken), 32'(bus.B_in));
    chk({pfx, ".branch_addr"},  bus.branch_addr, exp_ba);
    @(posedge clk);
    #1;
    if (!stall) begin
      m_wb = bus.wb_en_in; m_mr = bus.mem_read_in; m_mw = bus.mem_write_in;
      m_alu = res; m_st = rm; m_dest = bus.dest_in;
      if (bus.S_in) m_sr = nsr;
    end
    check_regs(pfx);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] so, input logic imm, input logic s);
    bus.exe_cmd_in = cmd; bus.val_Rn_in = rn; bus.val_Rm_in = rm;
    bus.shift_operand_in = so; bus.imm_in = imm; bus.S_in = s;
    bus.wb_en_in = 1'b1; bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0; bus.B_in = 1'b0;
    bus.PC_in = 32'h40; bus.signed_imm_24_in = 24'd3; bus.dest_in = 4'd7;
  endtask

  task automatic rand_inputs();
    bus.exe_cmd_in = 4'($urandom_range(0, 15));
    bus.val_Rn_in  = $urandom();
    case ($urandom_range(0, 5))
      0: bus.val_Rn_in = 32'h7FFFFFFF;
      1: bus.val_Rn_in = 32'h80000000;
      2: bus.val_Rn_in = 32'hFFFFFFFF;
      default: ;
    endcase
    bus.val_Rm_in        = $urandom();
    bus.shift_operand_in = 12'($urandom());
    bus.imm_in           = 1'($urandom_range(0, 1));
    bus.S_in             = 1'($urandom_range(0, 1));
    bus.wb_en_in         = 1'($urandom_range(0, 1));
    bus.mem_read_in      = ($urandom_range(0, 5) == 0);
    bus.mem_write_in     = ($urandom_range(0, 5) == 0);
    bus.B_in             = ($urandom_range(0, 7) == 0);
    bus.PC_in            = $urandom();
    bus.signed_imm_24_in = 24'($urandom());
    bus.dest_in          = 4'($urandom());
`ifdef FORWARDING_EN
    bus.sel_src1    = 2'($urandom_range(0, 3));
    bus.sel_src2    = 2'($urandom_range(0, 3));
    bus.fwd_mem_val = $urandom();
    bus.fwd_wb_val  = $urandom();
`endif
  endtask

  initial begin
    clk = 0; rst = 1; stall = 0; n_checks = 0; n_err = 0;
    set_op(4'd0, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    bus.sel_src1 = 0; bus.sel_src2 = 0; bus.fwd_mem_val = 0; bus.fwd_wb_val = 0;
`endif
    #1 rst = 0;
    #1;
    model_reset();
    check_regs("reset");
    @(negedge clk);
    rst = 1;

    // Signed overflow on ADD
    set_op(4'b0010, 32'h7FFFFFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    cycle("add_ovf");
    chk("add_ovf.const_alu", bus.alu_res, 32'h80000000);
    chk("add_ovf.const_sr", 32'(bus.SR), 32'h9);

    set_op(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
    cycle("sub_eq");
    chk("sub_eq.const_alu", bus.alu_res, 32'd0);
    chk("sub_eq.const_sr", 32'(bus.SR), 32'h6);

    set_op(4'b0011, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
    cycle("adc");
    chk("adc.const_alu", bus.alu_res, 32'd3);

    set_op(4'b0001, 32'd0, 32'd0, 12'h1FF, 1'b1, 1'b0);
    cycle("mov_rot");
    chk("mov_rot.const_alu", bus.alu_res, 32'hC000003F);

    set_op(4'b0001, 32'd0, 32'h80000000, 12'h240, 1'b0, 1'b0);
    cycle("mov_asr");
    chk("mov_asr.const_alu", bus.alu_res, 32'hF8000000);

    set_op(4'b0001, 32'd0, 32'h12345678, 12'h060, 1'b0, 1'b1);
    cycle("ror0");
    chk("ror0.const_alu", bus.alu_res, 32'h12345678);

    set_op(4'b0000, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
    bus.B_in = 1'b1; bus.wb_en_in = 1'b0; bus.PC_in = 32'h100; bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("branch.const_taken", 32'(bus.branch_taken), 32'd1);
    chk("branch.const_addr", bus.branch_addr, 32'hF8);
    cycle("branch");

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle("stall");
    end
    stall = 0;

`ifdef FORWARDING_EN
    set_op(4'b0010, 32'd77, 32'd0, 12'h001, 1'b1, 1'b0);
    bus.sel_src1 = 2'b01; bus.fwd_mem_val = 32'd9;
    cycle("fwd");
    chk("fwd.const_alu", bus.alu_res, 32'd10);
    bus.sel_src1 = 2'b00;
`endif

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    stall = 0;

    // Asynchronous reset in mid-cycle, then held across an edge together with stall.
    set_op(4'b0111, 32'hF0F0F0F0, 32'h0F, 12'h0, 1'b0, 1'b1);
    cycle("pre_rst");
    rand_inputs();
    #2 rst = 0;
    #1;
    model_reset();
    check_regs("mid_rst");
    stall = 1;
    @(posedge clk);
    #1;
    check_regs("rst_stall");
    @(negedge clk);
    rst = 1; stall = 0;
    rand_inputs();
    cycle("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
